uart_rx_param: RTL and testbench

Parametrised UART receiver that replaces the fixed clock-divider/receiver pair. Built around a single clock domain with an internal oversampling tick generator. Adds configurable data width, parity mode, stop-bit count, frame/parity error reporting, and a valid/ready output handshake with overrun detection. Sits between the board-level rxd pin and any byte-stream consumer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_param.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clock cycles per oversampling tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator with a synchronous clear.
// Emits a one-cycle tick when the counter reaches DIV-1, then wraps to 0.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(DIV - 1));

  // Divider counter; clr realigns the phase to an external event.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampling FSM,
// parity/frame checking and a valid/ready output with overrun detection.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of the samples around mid-bit instead of a single mid-bit sample.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = 4;
`ifdef UART_RX_MAJORITY_EN
  // Decision moves one tick later so the third majority sample exists.
  localparam int unsigned START_TGT = OVERSAMPLE / 2 + 1;
`else
  localparam int unsigned START_TGT = OVERSAMPLE / 2;
`endif
  localparam logic [OS_W-1:0]  START_LAST = OS_W'(START_TGT - 1);
  localparam logic [OS_W-1:0]  BIT_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR    = (PARITY == PAR_ODD);

  state_t              state, state_next;
  logic                rxd_s1, rxd_s2, rxd_s3;
  logic                fall;
  logic                tick, tick_clr;
  logic                bit_done;
  logic                sample_bit;
  logic [OS_W-1:0]     os_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                par_err_q, frm_err_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Input synchroniser plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign fall = rxd_s3 & ~rxd_s2;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_sh;

  // Keep the two previous tick samples; with the current one they span mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      maj_sh <= '1;
    end else if (tick) begin
      maj_sh <= {maj_sh[0], rxd_s2};
    end
  end

  assign sample_bit = (maj_sh[1] & maj_sh[0]) | (maj_sh[1] & rxd_s2) |
                      (maj_sh[0] & rxd_s2);
`else
  assign sample_bit = rxd_s2;
`endif

  assign bit_done = tick && (os_cnt == ((state == S_START) ? START_LAST : BIT_LAST));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a start edge during DONE goes straight to START.
  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fall) begin
          state_next = S_START;
          tick_clr   = 1'b1;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next = sample_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done && (bit_cnt == DATA_LAST)) begin
          state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done && (bit_cnt == STOP_LAST)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (fall) begin
          state_next = S_START;
          tick_clr   = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Tick/bit counters, data shifter and per-frame error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      if (tick_clr) begin
        os_cnt <= '0;
      end else if (tick && (state != S_IDLE) && (state != S_DONE)) begin
        os_cnt <= bit_done ? '0 : os_cnt + OS_W'(1);
      end
      unique case (state)
        S_START: begin
          bit_cnt   <= '0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
        end
        S_DATA: begin
          if (bit_done) begin
            shreg   <= {sample_bit, shreg[DATA_W-1:1]};
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            par_err_q <= sample_bit != ((^shreg) ^ ODD_PAR);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (!sample_bit) begin
              frm_err_q <= 1'b1;
            end
            bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output handshake and commit; accept and commit in one cycle reloads data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (state == S_DONE) begin
        if (frm_err_q) begin
          frame_err <= 1'b1;
        end else if (data_valid && !data_ready) begin
          overrun <= 1'b1;
        end else begin
          data       <= shreg;
          data_valid <= 1'b1;
          parity_err <= par_err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT = 27 * 16;  // clock cycles per bit at 50 MHz / 115200 x16

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  int errors = 0;
  int checks = 0;
  int fe_a_n = 0, pe_a_n = 0, ov_a_n = 0;
  int fe_b_n = 0, pe_b_n = 0, ov_b_n = 0;
  int fe0, pe0, ov0;

  always #5 clk = ~clk;

  uart_rx_param u8 (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd_a),
    .data       (data_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .frame_err  (fe_a),
    .parity_err (pe_a),
    .overrun    (ov_a)
  );

  uart_rx_param #(
    .PARITY (2)
  ) u8e (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd_b),
    .data       (data_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .frame_err  (fe_b),
    .parity_err (pe_b),
    .overrun    (ov_b)
  );

  // Count error pulses away from the active edge.
  always @(negedge clk) begin
    if (fe_a) fe_a_n <= fe_a_n + 1;
    if (pe_a) pe_a_n <= pe_a_n + 1;
    if (ov_a) ov_a_n <= ov_a_n + 1;
    if (fe_b) fe_b_n <= fe_b_n + 1;
    if (pe_b) pe_b_n <= pe_b_n + 1;
    if (ov_b) ov_b_n <= ov_b_n + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ready(input int sel);
    if (sel == 0) ready_a = 1'b1;
    else ready_b = 1'b1;
    cyc(1);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  // Frame: start, 8 data bits LSB first, optional parity bit, one stop bit.
  // spike_idx selects a frame bit that gets a 1-cycle inversion at its mid sample.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                            input logic par_bit, input logic stop_low, input int spike_idx);
    logic [10:0] fr;
    int n;
    fr = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      fr[n] = d[i];
      n++;
    end
    if (use_par) begin
      fr[n] = par_bit;
      n++;
    end
    fr[n] = ~stop_low;
    n++;
    for (int j = 0; j < n; j++) begin
      set_line(sel, fr[j]);
      if (j == spike_idx) begin
        cyc(217);
        set_line(sel, ~fr[j]);
        cyc(1);
        set_line(sel, fr[j]);
        cyc(BIT - 218);
      end else begin
        cyc(BIT);
      end
    end
    set_line(sel, 1'b1);
    cyc(2);
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_data", 32'(data_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_pulses", 32'({fe_a, pe_a, ov_a}), 32'h0);
    check("rst_state", 32'(u8.state), 32'(S_IDLE));
    rst = 1'b0;
    cyc(5);

    // Basic 8N1 word held until accepted
    fe0 = fe_a_n; pe0 = pe_a_n; ov0 = ov_a_n;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, -1);
    check("a5_data", 32'(data_a), 32'hA5);
    check("a5_valid", 32'(valid_a), 32'h1);
    cyc(50);
    check("a5_hold", 32'(valid_a), 32'h1);
    check("a5_no_err", 32'(fe_a_n - fe0 + pe_a_n - pe0 + ov_a_n - ov0), 32'h0);
    pulse_ready(0);
    check("a5_accept", 32'(valid_a), 32'h0);

    // Stop bit low: word dropped, frame_err once, then a good frame
    fe0 = fe_a_n;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
    check("fe_pulse", 32'(fe_a_n - fe0), 32'h1);
    check("fe_valid", 32'(valid_a), 32'h0);
    check("fe_data_kept", 32'(data_a), 32'hA5);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b0, -1);
    check("after_fe_data", 32'(data_a), 32'h12);
    check("after_fe_valid", 32'(valid_a), 32'h1);
    pulse_ready(0);

    // Overrun: second word arrives while the first is unread
    ov0 = ov_a_n;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0, -1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0, -1);
    check("ov_pulse", 32'(ov_a_n - ov0), 32'h1);
    check("ov_data_kept", 32'(data_a), 32'h11);
    check("ov_valid", 32'(valid_a), 32'h1);
    pulse_ready(0);
    check("ov_accept", 32'(valid_a), 32'h0);

    // 3-cycle low glitch is rejected at the start-bit check
    fe0 = fe_a_n; pe0 = pe_a_n;
    rxd_a = 1'b0;
    cyc(3);
    rxd_a = 1'b1;
    cyc(2 * BIT);
    check("glitch_valid", 32'(valid_a), 32'h0);
    check("glitch_err", 32'(fe_a_n - fe0 + pe_a_n - pe0), 32'h0);
    check("glitch_idle", 32'(u8.state), 32'(S_IDLE));

    // Break: one frame error, no retrigger on a steady low
    fe0 = fe_a_n;
    rxd_a = 1'b0;
    cyc(12 * BIT);
    rxd_a = 1'b1;
    cyc(BIT);
    check("break_fe_once", 32'(fe_a_n - fe0), 32'h1);
    check("break_valid", 32'(valid_a), 32'h0);
    check("break_idle", 32'(u8.state), 32'(S_IDLE));

    // Even parity: 0x3C has four ones, parity bit 0 is correct
    pe0 = pe_b_n;
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b0, -1);
    check("par_ok_data", 32'(data_b), 32'h3C);
    check("par_ok_noerr", 32'(pe_b_n - pe0), 32'h0);
    pulse_ready(1);
    pe0 = pe_b_n;
    fe0 = fe_b_n;
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b0, -1);
    check("par_bad_data", 32'(data_b), 32'h3C);
    check("par_bad_valid", 32'(valid_b), 32'h1);
    check("par_bad_pulse", 32'(pe_b_n - pe0), 32'h1);
    check("par_bad_nofe", 32'(fe_b_n - fe0), 32'h0);
    pulse_ready(1);

`ifdef UART_RX_MAJORITY_EN
    // Spike on the mid sample of data bit 3 (frame bit 4) is outvoted
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b0, 4);
    check("maj_data", 32'(data_a), 32'hF0);
    check("maj_valid", 32'(valid_a), 32'h1);
    pulse_ready(0);
`endif

    // Reset during DATA clears everything; the next frame is clean
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
    check("pre_rst_data", 32'(data_a), 32'h5A);
    rxd_a = 1'b0;
    cyc(BIT);
    rxd_a = 1'b1;
    cyc(BIT / 2);
    check("pre_rst_state", 32'(u8.state), 32'(S_DATA));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_data", 32'(data_a), 32'h0);
    check("mid_rst_valid", 32'(valid_a), 32'h0);
    check("mid_rst_state", 32'(u8.state), 32'(S_IDLE));
    cyc(12 * BIT);
    check("post_rst_quiet", 32'(valid_a), 32'h0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, -1);
    check("post_rst_data", 32'(data_a), 32'h81);
    check("post_rst_valid", 32'(valid_a), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
